alu_spi_master: RTL
===================

// Module: alu_spi_master
// PURPOSE
// - Bus master for the serial ALU/shifter slaves; the stage directly upstream of the slaves.
// - Accepts one operation {op_2, op_1, op_code} from the host over a valid/ready port.
// - Selects one slave, serializes the AluPacket onto MOSI, waits for the slave's ready flag,
//   then deserializes the REGISTER_SIZE-bit result from MISO.
// - Returns result + status on a valid/ready response port. One transaction in flight.
// PARAMETERS
// - NUM_SLAVES  4    number of slave-select lines / MISO inputs
// - TIMEOUT     255  max cycles in WAIT before abort; 1..65535
// - SEL_W       $clog2(NUM_SLAVES) (derived, localparam)
// - PKT_W       $bits(AluPacket) (derived, localparam)
// PORTS
// - i_clock      in   1             rising-edge clock
// - i_reset      in   1             synchronous, active-low reset
// - i_req_valid  in   1             request valid
// - o_req_ready  out  1             high only in IDLE
// - i_req_slave  in   SEL_W         target slave index
// - i_req_op     in   Instruction   op_code
// - i_req_op_1   in   REGISTER_SIZE operand 1
// - i_req_op_2   in   REGISTER_SIZE operand 2
// - o_rsp_valid  out  1             response valid, held until accepted
// - i_rsp_ready  in   1             response accept
// - o_rsp_data   out  REGISTER_SIZE result (0 on error)
// - o_rsp_error  out  1             1 = timeout or bad slave index
// - o_mosi       out  1             serial data to slaves
// - o_nss        out  NUM_SLAVES    active-low selects, at most one low
// - i_miso       in   NUM_SLAVES    serial data from slaves
// BEHAVIOUR
// - Reset (i_reset==0 at posedge): state IDLE, o_nss all 1, o_mosi 0, o_rsp_valid 0,
//   o_rsp_data 0, o_rsp_error 0, counters 0. Applies from any state; abandons the transfer.
// - States and outputs:
//   IDLE:   o_req_ready=1. On i_req_valid, latch packet/slave; go SELECT.
//           If i_req_slave>=NUM_SLAVES, go DONE with error and leave the bus untouched.
//   SELECT: 1 cycle; o_nss[sel]=0, o_mosi=0.
//   START:  1 cycle; o_mosi=1 (start bit).
//   TX:     PKT_W cycles; o_mosi=pkt[bit_cnt], bit 0 first; bit_cnt 0..PKT_W-1.
//   WAIT:   o_mosi=0. i_miso[sel]==1 -> RX. wait_cnt==TIMEOUT-1 without it -> DONE, error.
//   RX:     REGISTER_SIZE cycles; rsp[bit_cnt] <= i_miso[sel], bit 0 first.
//   DONE:   o_nss all 1, o_rsp_valid=1. Hold data until i_rsp_ready, then go IDLE.
// - Packet layout: {op_2, op_1, op_code}; op_code occupies the LSBs and is sent first.
// - Latency: o_rsp_valid rises PKT_W+REGISTER_SIZE+4 cycles after the request handshake,
//   for a slave that raises MISO 1 cycle after its last received bit.
// - o_nss[sel] stays low continuously from SELECT through the last RX cycle.
// - The ready flag is sampled only in WAIT; MISO data in RX is never treated as ready.
// - Timeout leaves that slave in its send state; recovering it is the system reset's job.
// - No new request is accepted in the same cycle a response is accepted (IDLE gap >= 1).
// STRUCTURE
// - Isa package: REGISTER_SIZE, Instruction, AluPacket (reuse existing types, no copies).
// - Local typedef enum for the states.
// - One natural sub-module: spi_bit_counter (load/enable/terminal-count). Serves bit_cnt
//   and wait_cnt. Otherwise a single always_ff and one always_comb.
// TESTING (shifter slave model; REGISTER_SIZE=16, 4-bit Instruction, PKT_W=36)
// - op 'h4, op_1=16'h8001, op_2=1, slave 2 -> rsp_data 16'h0003, error 0;
//   o_rsp_valid exactly 56 cycles after accept.
// - op 'h5, op_1=16'h0001, op_2=4, slave 0 -> rsp_data 16'h1000; only o_nss[0] goes low.
// - Slave model never raises MISO, TIMEOUT=20 -> error 1, data 0 after 20 WAIT cycles;
//   o_nss back to all 1.
// - i_req_slave=5 with NUM_SLAVES=4 -> error response 1 cycle after accept;
//   o_nss and o_mosi never change.
// - i_rsp_ready low for 10 cycles -> data/valid stable, o_req_ready 0; second request
//   completes normally afterwards.
// - Reset asserted at TX bit 10 -> next cycle o_nss all 1, o_mosi 0, o_req_ready 1;
//   new request after slave reset completes correctly.

Source files
------------

// File: rtl/alu_spi_master_pkg.sv
// -----------------------------------------------------------------------------
// alu_spi_master_pkg
// Shared ISA definitions for the serial ALU/shifter slaves and their bus master.
//   REGISTER_SIZE : width of operands and results
//   Instruction   : 4-bit opcode carried in the packet LSBs
//   AluPacket     : {op_2, op_1, op_code}. Because op_code is the last member
//                   of the packed struct, it lands in the LSBs and goes out first
//                   on a serial link.
// -----------------------------------------------------------------------------
package alu_spi_master_pkg;

    localparam int REGISTER_SIZE = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_ROL = 4'h4,
        OP_ROR = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7
    } Instruction;

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        Instruction               op_code;
    } AluPacket;

endpackage

// File: rtl/alu_spi_master_spi_bit_counter.sv
// -----------------------------------------------------------------------------
// spi_bit_counter
// Up-counter with a synchronous clear and a terminal-count flag. The master uses
// one instance for serial bit positions and another for the ready-flag timeout.
//   i_clock    : rising-edge clock
//   i_reset    : synchronous, active-low reset
//   i_load     : clear the count to zero (takes priority over i_enable)
//   i_enable   : advance the count by one
//   i_terminal : value at which o_done is asserted
//   o_done     : count equals i_terminal
// -----------------------------------------------------------------------------
module spi_bit_counter #(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_enable,
    input  logic [W-1:0] i_terminal,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_done = (r_count == i_terminal);

endmodule

// File: rtl/alu_spi_master.sv
// -----------------------------------------------------------------------------
// alu_spi_master
// Bus master for the serial ALU/shifter slaves. It takes one operation from the
// host, sends it to one slave as a start bit followed by the AluPacket (LSB
// first), waits for the slave's ready flag on MISO, then shifts in the result
// (LSB first) and presents it on the response port. One transaction in flight.
//   i_clock / i_reset        : clock, synchronous active-low reset
//   i_req_valid/o_req_ready  : request handshake (ready only while idle)
//   i_req_slave              : target slave; out-of-range gives an error response
//   i_req_op/_op_1/_op_2     : opcode and operands
//   o_rsp_valid/i_rsp_ready  : response handshake, held until accepted
//   o_rsp_data/o_rsp_error   : result (0 on error), error = timeout or bad index
//   o_mosi, o_nss, i_miso    : serial bus, o_nss active-low, at most one low
// -----------------------------------------------------------------------------
module alu_spi_master
    import alu_spi_master_pkg::*;
#(
    parameter  int NUM_SLAVES = 4,
    parameter  int TIMEOUT    = 255,
    // One extra bit so the host can present indices beyond the populated
    // slaves; those are answered with an error instead of aliasing onto a slave.
    localparam int SEL_W      = $clog2(NUM_SLAVES) + 1,
    localparam int PKT_W      = $bits(AluPacket)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [SEL_W-1:0]         i_req_slave,
    input  Instruction               i_req_op,
    input  logic [REGISTER_SIZE-1:0] i_req_op_1,
    input  logic [REGISTER_SIZE-1:0] i_req_op_2,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [REGISTER_SIZE-1:0] o_rsp_data,
    output logic                     o_rsp_error,
    output logic                     o_mosi,
    output logic [NUM_SLAVES-1:0]    o_nss,
    input  logic [NUM_SLAVES-1:0]    i_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_TX,
        ST_WAIT,
        ST_RX,
        ST_DONE
    } state_t;

    localparam int                BIT_W       = $clog2(PKT_W);
    localparam int                WAIT_W      = 16;
    localparam logic [SEL_W-1:0]  SLAVE_LIMIT = SEL_W'(NUM_SLAVES);
    localparam logic [BIT_W-1:0]  TX_LAST     = BIT_W'(PKT_W - 1);
    localparam logic [BIT_W-1:0]  RX_LAST     = BIT_W'(REGISTER_SIZE - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

    state_t                   r_state;
    logic [PKT_W-1:0]         r_shift;
    logic [NUM_SLAVES-1:0]    r_nss;
    logic                     r_mosi;
    logic                     r_req_ready;
    logic                     r_rsp_valid;
    logic                     r_rsp_error;
    logic [REGISTER_SIZE-1:0] r_rsp_data;

    AluPacket                 w_req_pkt;
    logic [NUM_SLAVES-1:0]    w_req_sel;
    logic                     w_miso_sel;
    logic                     w_bit_load;
    logic                     w_bit_en;
    logic                     w_bit_done;
    logic [BIT_W-1:0]         w_bit_last;
    logic                     w_wait_load;
    logic                     w_wait_en;
    logic                     w_wait_done;

    assign w_req_pkt = '{op_2: i_req_op_2, op_1: i_req_op_1, op_code: i_req_op};
    assign w_req_sel = NUM_SLAVES'(1) << i_req_slave;
    // The low select line itself marks the addressed slave, so MISO is picked
    // through it; unselected lines are masked off whatever they carry.
    assign w_miso_sel = |(i_miso & ~r_nss);

    // Counters are held at zero outside the states that use them, so they
    // always start from bit 0 / wait cycle 0 on entry.
    always_comb begin
        w_bit_en    = (r_state == ST_TX) || (r_state == ST_RX);
        w_bit_load  = !w_bit_en;
        w_bit_last  = (r_state == ST_TX) ? TX_LAST : RX_LAST;
        w_wait_en   = (r_state == ST_WAIT);
        w_wait_load = !w_wait_en;
    end

    spi_bit_counter #(.W(BIT_W)) u_bit_cnt (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_bit_load),
        .i_enable   (w_bit_en),
        .i_terminal (w_bit_last),
        .o_done     (w_bit_done)
    );

    spi_bit_counter #(.W(WAIT_W)) u_wait_cnt (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_wait_load),
        .i_enable   (w_wait_en),
        .i_terminal (WAIT_LAST),
        .o_done     (w_wait_done)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_nss       <= '1;
            r_mosi      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_shift     <= w_req_pkt;
                        r_rsp_data  <= '0;
                        r_req_ready <= 1'b0;
                        if (i_req_slave >= SLAVE_LIMIT) begin
                            // Bad index: answer at once, bus untouched.
                            r_rsp_error <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_rsp_error <= 1'b0;
                            r_nss       <= ~w_req_sel;
                            r_mosi      <= 1'b0;
                            r_state     <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    r_mosi  <= 1'b1;
                    r_state <= ST_START;
                end
                ST_START: begin
                    // Outputs are registered, so the next bit is staged one
                    // cycle ahead from the shift register's LSB.
                    r_mosi  <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_state <= ST_TX;
                end
                ST_TX: begin
                    if (w_bit_done) begin
                        r_mosi  <= 1'b0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_mosi  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                ST_WAIT: begin
                    if (w_miso_sel) begin
                        r_state <= ST_RX;
                    end else if (w_wait_done) begin
                        r_nss       <= '1;
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_RX: begin
                    // Shift in from the top: after REGISTER_SIZE bits the first
                    // received bit sits in bit 0.
                    r_rsp_data <= {w_miso_sel, r_rsp_data[REGISTER_SIZE-1:1]};
                    if (w_bit_done) begin
                        r_nss       <= '1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_nss       <= '1;
                    r_mosi      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_error = r_rsp_error;
    assign o_mosi      = r_mosi;
    assign o_nss       = r_nss;

endmodule
